// File: rtl/clock_time_counter.sv
// ============================================================================
// clock_time_counter
// ----------------------------------------------------------------------------
// Time-of-day counter driven by the strobes of the reference-clock strobe
// stage. Keeps binary HH:MM:SS for the BCD/display stages downstream.
//
//   RUN  (both set inputs low) : seconds advance on every 1 Hz strobe, with a
//                                full same-cycle ripple into minutes/hours.
//   SET  (either set input high): seconds are held at 0; a fast divider counts
//                                refclk strobes and every FAST_SET_DIV of them
//                                steps the selected field(s).
//
// Parameters
//   FAST_SET_DIV  fast strobes per set-mode step, 1..65536
//
// Ports
//   i_clk          in   system clock, rising edge
//   i_reset        in   synchronous active-high reset
//   i_en           in   block enable; low freezes all state, strobes are lost
//   i_1hz_stb      in   one-cycle 1 Hz strobe
//   i_fast_stb     in   one-cycle strobe per refclk rising edge
//   i_set_hours    in   level: step hours while high
//   i_set_minutes  in   level: step minutes while high
//   o_hours        out  5-bit binary hours   0..23
//   o_minutes      out  6-bit binary minutes 0..59
//   o_seconds      out  6-bit binary seconds 0..59
//   o_update       out  one-cycle pulse coincident with any time change
// ============================================================================
module clock_time_counter #(
    parameter int FAST_SET_DIV = 4096
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_1hz_stb,
    input  logic       i_fast_stb,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic       o_update
);

    // A divide-by-1 still needs a one-bit register to keep the code uniform;
    // its terminal count is 0, so every fast strobe becomes a step.
    localparam int DIV_W = (FAST_SET_DIV > 1) ? $clog2(FAST_SET_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FAST_SET_DIV - 1);

    localparam logic [4:0] HOURS_LAST   = 5'd23;
    localparam logic [5:0] MINUTES_LAST = 6'd59;
    localparam logic [5:0] SECONDS_LAST = 6'd59;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [4:0]       hours_reg,   hours_next;
    logic [5:0]       minutes_reg, minutes_next;
    logic [5:0]       seconds_reg, seconds_next;
    logic [DIV_W-1:0] div_reg,     div_next;
    logic             update_reg,  update_next;

    // ------------------------------------------------------------------------
    // Field increment helpers (wrap at the field's last value)
    // ------------------------------------------------------------------------
    logic       set_mode;
    logic       sec_at_last;
    logic       min_at_last;
    logic       hr_at_last;
    logic [4:0] hours_inc;
    logic [5:0] minutes_inc;
    logic [5:0] seconds_inc;
    logic       div_at_last;
    logic       set_step;

    assign set_mode    = i_set_hours | i_set_minutes;

    assign sec_at_last = (seconds_reg == SECONDS_LAST);
    assign min_at_last = (minutes_reg == MINUTES_LAST);
    assign hr_at_last  = (hours_reg   == HOURS_LAST);

    assign seconds_inc = sec_at_last ? 6'd0 : seconds_reg + 6'd1;
    assign minutes_inc = min_at_last ? 6'd0 : minutes_reg + 6'd1;
    assign hours_inc   = hr_at_last  ? 5'd0 : hours_reg   + 5'd1;

    assign div_at_last = (div_reg == DIV_LAST);
    // A step is the fast strobe that wraps the divider.
    assign set_step    = set_mode & i_fast_stb & div_at_last;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        hours_next   = hours_reg;
        minutes_next = minutes_reg;
        seconds_next = seconds_reg;
        div_next     = div_reg;
        update_next  = 1'b0;

        if (i_en) begin
            if (set_mode) begin
                // Seconds are parked at zero for the whole time the user is
                // setting, so the clock restarts cleanly on release.
                seconds_next = 6'd0;

                if (i_fast_stb) begin
                    if (div_at_last) begin
                        div_next = '0;
                    end else begin
                        div_next = div_reg + 1'b1;
                    end
                end

                // Minutes wrap without carrying into hours while setting.
                if (set_step) begin
                    if (i_set_minutes) begin
                        minutes_next = minutes_inc;
                    end
                    if (i_set_hours) begin
                        hours_next = hours_inc;
                    end
                end
            end else begin
                // The divider sits at 0 in RUN so the first set step always
                // takes a full FAST_SET_DIV strobes.
                div_next = '0;

                if (i_1hz_stb) begin
                    seconds_next = seconds_inc;
                    if (sec_at_last) begin
                        minutes_next = minutes_inc;
                        if (min_at_last) begin
                            hours_next = hours_inc;
                        end
                    end
                end
            end

            // Pulse only on a real change: a strobe that leaves the time as
            // it was (e.g. seconds already 0 in SET) gives no update.
            update_next = (hours_next   != hours_reg)   ||
                          (minutes_next != minutes_reg) ||
                          (seconds_next != seconds_reg);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hours_reg   <= '0;
            minutes_reg <= '0;
            seconds_reg <= '0;
            div_reg     <= '0;
            update_reg  <= 1'b0;
        end else begin
            hours_reg   <= hours_next;
            minutes_reg <= minutes_next;
            seconds_reg <= seconds_next;
            div_reg     <= div_next;
            update_reg  <= update_next;
        end
    end

    assign o_hours   = hours_reg;
    assign o_minutes = minutes_reg;
    assign o_seconds = seconds_reg;
    assign o_update  = update_reg;

endmodule

// File: tb/tb_clock_time_counter.sv
// ============================================================================
// tb_clock_time_counter
// ----------------------------------------------------------------------------
// Two instances share all inputs: index 0 divides fast strobes by 4, index 1
// by 1. A reference model keeps each instance's time as plain integers and
// advances it from the stimulus, independent of the design's structure.
// ============================================================================
module tb_clock_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, hz, fast, sh, sm;

    logic [4:0] h4, h1;
    logic [5:0] m4, m1, s4, s1;
    logic       u4, u1;

    clock_time_counter #(.FAST_SET_DIV(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz),
        .i_fast_stb(fast), .i_set_hours(sh), .i_set_minutes(sm),
        .o_hours(h4), .o_minutes(m4), .o_seconds(s4), .o_update(u4)
    );

    clock_time_counter #(.FAST_SET_DIV(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz),
        .i_fast_stb(fast), .i_set_hours(sh), .i_set_minutes(sm),
        .o_hours(h1), .o_minutes(m1), .o_seconds(s1), .o_update(u1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state per instance
    int mh[2], mm[2], ms[2], mdiv[2];
    bit mupd[2];
    int dv[2] = '{4, 1};

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int oh, om, os, t;
            oh = mh[k]; om = mm[k]; os = ms[k];
            if (rst) begin
                mh[k] = 0; mm[k] = 0; ms[k] = 0; mdiv[k] = 0; mupd[k] = 0;
            end else if (!en) begin
                mupd[k] = 0;
            end else begin
                if (sh || sm) begin
                    ms[k] = 0;
                    if (fast) begin
                        if (mdiv[k] == dv[k] - 1) begin
                            mdiv[k] = 0;
                            if (sm) mm[k] = (mm[k] + 1) % 60;
                            if (sh) mh[k] = (mh[k] + 1) % 24;
                        end else begin
                            mdiv[k] = mdiv[k] + 1;
                        end
                    end
                end else begin
                    mdiv[k] = 0;
                    if (hz) begin
                        t = (mh[k] * 3600 + mm[k] * 60 + ms[k] + 1) % 86400;
                        mh[k] = t / 3600;
                        mm[k] = (t / 60) % 60;
                        ms[k] = t % 60;
                    end
                end
                mupd[k] = (mh[k] != oh) || (mm[k] != om) || (ms[k] != os);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] expv(int k);
        return {5'(mh[k]), 6'(mm[k]), 6'(ms[k]), mupd[k]};
    endfunction

    function automatic logic [17:0] actv(int k);
        return (k == 1) ? {h1, m1, s1, u1} : {h4, m4, s4, u4};
    endfunction

    function automatic string fmt(logic [17:0] v);
        return $sformatf("%0d:%0d:%0d upd=%0b", v[17:13], v[12:7], v[6:1], v[0]);
    endfunction

    function automatic logic [17:0] tv(int h, int m, int s, bit u);
        return {5'(h), 6'(m), 6'(s), u};
    endfunction

    task automatic pulse_hz(int n);
        repeat (n) begin
            hz = 1'b1; tick();
            hz = 1'b0; tick();
        end
    endtask

    task automatic pulse_fast(int n);
        repeat (n) begin
            fast = 1'b1; tick();
            fast = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; hz = 1'b0; fast = 1'b0; sh = 1'b0; sm = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (actv(k) !== tv(0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL reset_state dut%0d got %s want %s", k, fmt(actv(k)), fmt(tv(0, 0, 0, 0)));
            end
        end
        // Load 12:34:56 into the divide-by-1 instance
        sh = 1'b1; pulse_fast(12);
        sh = 1'b0; sm = 1'b1; pulse_fast(34);
        sm = 1'b0; tick();
        pulse_hz(56);
        n_cmp++;
        if (actv(1) !== tv(12, 34, 56, 0)) begin
            n_fail++;
            $display("FAIL load_123456 got %s want %s", fmt(actv(1)), fmt(tv(12, 34, 56, 0)));
        end
        n_cmp++;
        if (actv(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL load_div4 got %s want %s", fmt(actv(0)), fmt(expv(0)));
        end
        rst = 1'b1; hz = 1'b1; tick();
        rst = 1'b0; hz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (actv(k) !== tv(0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL reset_clear dut%0d got %s want %s", k, fmt(actv(k)), fmt(tv(0, 0, 0, 0)));
            end
        end
        $display("test_reset done");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_midnight();
        do_reset();
        sh = 1'b1; pulse_fast(23);
        sh = 1'b0; sm = 1'b1; pulse_fast(59);
        sm = 1'b0; tick();
        pulse_hz(59);
        n_cmp++;
        if (actv(1) !== tv(23, 59, 59, 0)) begin
            n_fail++;
            $display("FAIL pre_midnight got %s want %s", fmt(actv(1)), fmt(tv(23, 59, 59, 0)));
        end
        hz = 1'b1; tick();
        n_cmp++;
        if (actv(1) !== tv(0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL midnight_ripple got %s want %s", fmt(actv(1)), fmt(tv(0, 0, 0, 1)));
        end
        n_cmp++;
        if (actv(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL midnight_div4 got %s want %s", fmt(actv(0)), fmt(expv(0)));
        end
        hz = 1'b0; tick();
        n_cmp++;
        if (actv(1) !== tv(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL midnight_upd_width got %s want %s", fmt(actv(1)), fmt(tv(0, 0, 0, 0)));
        end
        $display("test_midnight done");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_run_hour();
        do_reset();
        pulse_hz(3600);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (actv(k) !== tv(1, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL run_3600 dut%0d got %s want %s", k, fmt(actv(k)), fmt(tv(1, 0, 0, 0)));
            end
        end
        do_reset();
        pulse_hz(59);
        n_cmp++;
        if (actv(1) !== tv(0, 0, 59, 0)) begin
            n_fail++;
            $display("FAIL run_59 got %s want %s", fmt(actv(1)), fmt(tv(0, 0, 59, 0)));
        end
        pulse_hz(60);
        n_cmp++;
        if (actv(1) !== tv(0, 1, 59, 0)) begin
            n_fail++;
            $display("FAIL run_60_more got %s want %s", fmt(actv(1)), fmt(tv(0, 1, 59, 0)));
        end
        $display("test_run_hour done");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_set_minutes();
        do_reset();
        pulse_hz(5);
        sm = 1'b1; tick();
        n_cmp++;
        if (actv(0) !== tv(0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL set_sec_clear got %s want %s", fmt(actv(0)), fmt(tv(0, 0, 0, 1)));
        end
        pulse_fast(232);
        n_cmp++;
        if (actv(0) !== tv(0, 58, 0, 0)) begin
            n_fail++;
            $display("FAIL set_min_58 got %s want %s", fmt(actv(0)), fmt(tv(0, 58, 0, 0)));
        end
        n_cmp++;
        if (actv(1) !== expv(1)) begin
            n_fail++;
            $display("FAIL set_min_div1 got %s want %s", fmt(actv(1)), fmt(expv(1)));
        end
        // 1 Hz strobes interleaved with fast strobes must be ignored in SET
        for (int i = 0; i < 8; i++) begin
            fast = 1'b1; tick();
            fast = 1'b0; hz = 1'b1; tick();
            hz = 1'b0;
            n_cmp++;
            if (actv(0) !== expv(0)) begin
                n_fail++;
                $display("FAIL set_min_step%0d got %s want %s", i, fmt(actv(0)), fmt(expv(0)));
            end
        end
        n_cmp++;
        if (actv(0) !== tv(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL set_min_wrap got %s want %s", fmt(actv(0)), fmt(tv(0, 0, 0, 0)));
        end
        sm = 1'b0; tick();
        $display("test_set_minutes done");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_set_both();
        do_reset();
        sh = 1'b1; pulse_fast(23);
        sh = 1'b0; sm = 1'b1; pulse_fast(59);
        n_cmp++;
        if (actv(1) !== tv(23, 59, 0, 0)) begin
            n_fail++;
            $display("FAIL set_2359 got %s want %s", fmt(actv(1)), fmt(tv(23, 59, 0, 0)));
        end
        sh = 1'b1; fast = 1'b1; tick();
        n_cmp++;
        if (actv(1) !== tv(0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL set_both_wrap got %s want %s", fmt(actv(1)), fmt(tv(0, 0, 0, 1)));
        end
        n_cmp++;
        if (actv(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL set_both_div4 got %s want %s", fmt(actv(0)), fmt(expv(0)));
        end
        fast = 1'b0; tick();
        sh = 1'b0; sm = 1'b0; tick();
        hz = 1'b1; tick();
        n_cmp++;
        if (actv(1) !== tv(0, 0, 1, 1)) begin
            n_fail++;
            $display("FAIL release_run got %s want %s", fmt(actv(1)), fmt(tv(0, 0, 1, 1)));
        end
        hz = 1'b0; tick();
        $display("test_set_both done");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_enable_and_reset_mid_set();
        logic [17:0] held;
        do_reset();
        pulse_hz(3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hz = 1'b1; tick();
            hz = 1'b0;
            n_cmp++;
            if (actv(1) !== tv(0, 0, 3, 0)) begin
                n_fail++;
                $display("FAIL disabled_hold%0d got %s want %s", i, fmt(actv(1)), fmt(tv(0, 0, 3, 0)));
            end
            tick();
        end
        en = 1'b1; tick();
        n_cmp++;
        if (actv(1) !== tv(0, 0, 3, 0)) begin
            n_fail++;
            $display("FAIL strobes_lost got %s want %s", fmt(actv(1)), fmt(tv(0, 0, 3, 0)));
        end
        // Reset in the middle of a set-mode divide
        sm = 1'b1; pulse_fast(2);
        rst = 1'b1; tick();
        rst = 1'b0;
        n_cmp++;
        if (actv(0) !== tv(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_set got %s want %s", fmt(actv(0)), fmt(tv(0, 0, 0, 0)));
        end
        pulse_fast(3);
        held = tv(0, 0, 0, 0);
        n_cmp++;
        if (actv(0) !== held) begin
            n_fail++;
            $display("FAIL div_restart_3 got %s want %s", fmt(actv(0)), fmt(held));
        end
        pulse_fast(1);
        n_cmp++;
        if (actv(0) !== tv(0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL div_restart_4 got %s want %s", fmt(actv(0)), fmt(tv(0, 1, 0, 0)));
        end
        sm = 1'b0; tick();
        $display("test_enable_and_reset_mid_set done");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 40) == 0) sh = ~sh;
            if ($urandom_range(0, 40) == 0) sm = ~sm;
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 600) == 0);
            hz   = hz   ? 1'b0 : ($urandom_range(0, 2) == 0);
            fast = fast ? 1'b0 : ($urandom_range(0, 1) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (actv(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL random c=%0d dut%0d got %s want %s", c, k, fmt(actv(k)), fmt(expv(k)));
                end
            end
        end
        rst = 1'b0; hz = 1'b0; fast = 1'b0; sh = 1'b0; sm = 1'b0; en = 1'b1;
        tick();
        $display("test_random done, %0d new mismatches", n_fail - errs_before);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; hz = 1'b0; fast = 1'b0; sh = 1'b0; sm = 1'b0;
        test_reset();
        test_midnight();
        test_run_hour();
        test_set_minutes();
        test_set_both();
        test_enable_and_reset_mid_set();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
